// File: rtl/beep_sequencer.sv
// Beep pattern sequencer: plays one of four fixed ROM patterns into the beeper's
// enable/duty_cycle inputs, one step at a time, on a single-cycle start request.
module beep_sequencer #(
    parameter int unsigned TICK_DIV = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] pattern_sel,
    input  logic       stop,
    output logic       enable,
    output logic [3:0] duty_cycle,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    typedef struct packed {
        logic [3:0] duty;
        logic [3:0] len;
        logic       last;
        logic       loop;
    } step_t;

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    // Addressed by {pattern, step}; unused slots are inert single-tick last steps.
    localparam step_t ROM [16] = '{
        '{4'b1111, 4'd10, 1'b1, 1'b0}, '{4'b0000, 4'd1, 1'b1, 1'b0},
        '{4'b0000, 4'd1,  1'b1, 1'b0}, '{4'b0000, 4'd1, 1'b1, 1'b0},
        '{4'b1111, 4'd5,  1'b0, 1'b0}, '{4'b0000, 4'd5, 1'b0, 1'b0},
        '{4'b1111, 4'd5,  1'b1, 1'b0}, '{4'b0000, 4'd1, 1'b1, 1'b0},
        '{4'b1111, 4'd4,  1'b0, 1'b0}, '{4'b1110, 4'd4, 1'b0, 1'b0},
        '{4'b1100, 4'd4,  1'b0, 1'b0}, '{4'b1000, 4'd4, 1'b1, 1'b0},
        '{4'b1010, 4'd8,  1'b0, 1'b0}, '{4'b0000, 4'd8, 1'b1, 1'b1},
        '{4'b0000, 4'd1,  1'b1, 1'b0}, '{4'b0000, 4'd1, 1'b1, 1'b0}
    };

    state_t      state, state_n;
    logic [1:0]  pat, pat_n;
    logic [1:0]  step, step_n;
    logic [15:0] presc, presc_n;
    logic [3:0]  tick_cnt, tick_n;
    logic        done_n;
    step_t       cur;
    logic [3:0]  duty_n;

    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        state_n = state;
        pat_n   = pat;
        step_n  = step;
        presc_n = presc;
        tick_n  = tick_cnt;
        done_n  = 1'b0;
        cur     = ROM[{pat, step}];

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = PLAY;
                    pat_n   = pattern_sel;
                    step_n  = 2'd0;
                    presc_n = 16'd0;
                    tick_n  = 4'd0;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (presc == PRESC_MAX) begin
                    presc_n = 16'd0;
                    if (tick_cnt == cur.len - 4'd1) begin
                        tick_n = 4'd0;
                        if (!cur.last) begin
                            step_n = step + 2'd1;
                        end else if (cur.loop) begin
                            step_n = 2'd0;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + 4'd1;
                    end
                end else begin
                    presc_n = presc + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        duty_n = (state_n == PLAY) ? ROM[{pat_n, step_n}].duty : 4'b0000;
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pat        <= 2'd0;
            step       <= 2'd0;
            presc      <= 16'd0;
            tick_cnt   <= 4'd0;
            enable     <= 1'b0;
            duty_cycle <= 4'b0000;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            pat        <= pat_n;
            step       <= step_n;
            presc      <= presc_n;
            tick_cnt   <= tick_n;
            enable     <= (duty_n != 4'b0000);
            duty_cycle <= duty_n;
            busy       <= (state_n == PLAY);
            done       <= done_n;
        end
    end

endmodule
